// File: rtl/uart_pkg.sv
// ============================================================================
// uart_pkg : shared types and constants for the multi-byte UART receiver
// Revision : 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    GAP       = 3'd4,
    WAIT_HIGH = 3'd5
  } rx_state_t;

  localparam logic [1:0] ERR_FRAMING = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  localparam int DEFAULT_CLKS_PER_BIT = 5208;
  localparam int MAX_BYTES            = 16;

  // Index of the final byte of a message: 0 and 1 both mean one byte, >16 clamps.
  function automatic logic [3:0] last_idx(input logic [4:0] len);
    if (len <= 5'd1) begin
      return 4'd0;
    end else if (len >= 5'(MAX_BYTES)) begin
      return 4'(MAX_BYTES - 1);
    end else begin
      return 4'(len - 5'd1);
    end
  endfunction

endpackage

`default_nettype wire

// File: rtl/rx_bps_module.sv
// ============================================================================
// rx_bps_module : bit-period counter producing a one-cycle sample tick
// Revision      : 1.0
// ============================================================================
`default_nettype none

module rx_bps_module #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  input  logic i_half_load,
  output logic o_sample_tick
);

  localparam int            c_cw   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [c_cw-1:0] c_last = c_cw'(CLKS_PER_BIT - 1);
  // Preloading to the half point makes the first tick land mid start bit.
  localparam logic [c_cw-1:0] c_half = c_cw'(CLKS_PER_BIT / 2 - 1);

  logic [c_cw-1:0] r_cnt;
  logic            w_tick;

  assign w_tick        = i_en && (r_cnt == c_last);
  assign o_sample_tick = w_tick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_half_load) begin
      r_cnt <= c_half;
    end else if (!i_en || w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_rx_frame.sv
// ============================================================================
// uart_rx_frame : UART receiver assembling up to 16 bytes (MSB byte first)
//                 into one 128-bit message with done/error pulses
// Revision      : 1.0
// ============================================================================
`default_nettype none

module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_rx_pin_in,
  input  logic [4:0]   i_len,
  output logic [127:0] o_rx_data,
  output logic         o_rx_done,
  output logic         o_rx_busy,
  output logic         o_rx_err,
  output logic [1:0]   o_err_code
);

  localparam int c_tw = $clog2(TIMEOUT_BITS + 1);

  logic           r_sync1;
  logic           r_sync2;
  logic           w_rxs;
  rx_state_t      r_state;
  rx_state_t      w_next;
  logic [3:0]     r_byte_idx;
  logic [3:0]     r_last_idx;
  logic [2:0]     r_bit_idx;
  logic [7:0]     r_byte;
  logic [127:0]   r_shreg;
  logic [127:0]   w_shreg_next;
  logic [127:0]   r_rx_data;
  logic           r_done;
  logic           r_busy;
  logic           r_err;
  logic [1:0]     r_err_code;
  logic [c_tw-1:0] r_to_bits;

  logic           w_bit_tick;
  logic           w_to_tick;
  logic           w_bps_en;
  logic           w_to_run;
  logic           w_timeout;
  logic           w_last_byte;
  logic [3:0]     w_pos;
  logic           w_half_load;
  logic           w_first_start;
  logic           w_shift;
  logic           w_store;
  logic           w_done;
  logic           w_err;
  logic [1:0]     w_err_code_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_rx_pin_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rxs       = r_sync2;
  assign w_bps_en    = (r_state == START) || (r_state == DATA) || (r_state == STOP);
  // The gap timer keeps running through a false start seen between bytes.
  assign w_to_run    = (r_state == GAP) || ((r_state == START) && (r_byte_idx != 4'd0));
  assign w_timeout   = (r_to_bits == c_tw'(TIMEOUT_BITS));
  assign w_last_byte = (r_byte_idx == r_last_idx);
  assign w_pos       = r_last_idx - r_byte_idx;

  rx_bps_module #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_bit_bps (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_en         (w_bps_en),
    .i_half_load  (w_half_load),
    .o_sample_tick(w_bit_tick)
  );

  rx_bps_module #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_gap_bps (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_en         (w_to_run),
    .i_half_load  (1'b0),
    .o_sample_tick(w_to_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next        = r_state;
    w_half_load   = 1'b0;
    w_first_start = 1'b0;
    w_shift       = 1'b0;
    w_store       = 1'b0;
    w_done        = 1'b0;
    w_err         = 1'b0;
    w_err_code_n  = ERR_FRAMING;
    case (r_state)
      IDLE: begin
        if (!w_rxs) begin
          w_next      = START;
          w_half_load = 1'b1;
        end
      end
      START: begin
        if (w_bit_tick) begin
          if (w_rxs) begin
            w_next = (r_byte_idx != 4'd0) ? GAP : IDLE;
          end else begin
            w_next        = DATA;
            w_first_start = (r_byte_idx == 4'd0);
          end
        end
      end
      DATA: begin
        if (w_bit_tick) begin
          w_shift = 1'b1;
          if (r_bit_idx == 3'd7) begin
            w_next = STOP;
          end
        end
      end
      STOP: begin
        if (w_bit_tick) begin
          if (w_rxs) begin
            w_store = 1'b1;
            if (w_last_byte) begin
              w_done = 1'b1;
              w_next = IDLE;
            end else begin
              w_next = GAP;
            end
          end else begin
            w_err        = 1'b1;
            w_err_code_n = ERR_FRAMING;
            w_next       = WAIT_HIGH;
          end
        end
      end
      GAP: begin
        if (!w_rxs) begin
          w_next      = START;
          w_half_load = 1'b1;
        end else if (w_timeout) begin
          w_err        = 1'b1;
          w_err_code_n = ERR_TIMEOUT;
          w_next       = IDLE;
        end
      end
      WAIT_HIGH: begin
        if (w_rxs) begin
          w_next = IDLE;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_comb begin
    w_shreg_next = r_shreg;
    if (w_store) begin
      w_shreg_next[{w_pos, 3'b000} +: 8] = r_byte;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_byte_idx <= 4'd0;
      r_last_idx <= 4'd0;
      r_bit_idx  <= 3'd0;
      r_byte     <= 8'd0;
      r_shreg    <= '0;
      r_rx_data  <= '0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= 2'b00;
      r_to_bits  <= '0;
    end else begin
      r_done  <= w_done;
      r_err   <= w_err;
      r_shreg <= w_shreg_next;
      if (w_err) begin
        r_err_code <= w_err_code_n;
      end
      if (w_first_start) begin
        r_shreg    <= '0;
        r_last_idx <= last_idx(i_len);
        r_busy     <= 1'b1;
      end
      if (w_shift) begin
        r_byte    <= {w_rxs, r_byte[7:1]};
        r_bit_idx <= r_bit_idx + 1'b1;
      end
      if (w_store) begin
        r_byte_idx <= r_byte_idx + 1'b1;
      end
      if (w_done) begin
        r_rx_data  <= w_shreg_next;
        r_busy     <= 1'b0;
        r_byte_idx <= 4'd0;
      end
      if (w_err) begin
        r_busy     <= 1'b0;
        r_byte_idx <= 4'd0;
      end
      if (!w_to_run) begin
        r_to_bits <= '0;
      end else if (w_to_tick && !w_timeout) begin
        r_to_bits <= r_to_bits + 1'b1;
      end
    end
  end

  assign o_rx_data  = r_rx_data;
  assign o_rx_done  = r_done;
  assign o_rx_busy  = r_busy;
  assign o_rx_err   = r_err;
  assign o_err_code = r_err_code;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_frame.sv
// ============================================================================
// tb_uart_rx_frame : directed self-checking bench for uart_rx_frame
// Revision         : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uart_rx_frame;

  localparam int C  = 16;
  localparam int TO = 20;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         rx = 1'b1;
  logic [4:0]   len = 5'd0;
  logic [127:0] o_rx_data;
  logic         o_rx_done;
  logic         o_rx_busy;
  logic         o_rx_err;
  logic [1:0]   o_err_code;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  int overlap_cnt = 0;
  int bad_change  = 0;
  logic [127:0] last_data = '0;
  logic [127:0] prev_data;
  logic         busy_and = 1'b1;

  uart_rx_frame #(.CLKS_PER_BIT(C), .TIMEOUT_BITS(TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_rx_pin_in(rx),
    .i_len      (len),
    .o_rx_data  (o_rx_data),
    .o_rx_done  (o_rx_done),
    .o_rx_busy  (o_rx_busy),
    .o_rx_err   (o_rx_err),
    .o_err_code (o_err_code)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (o_rx_done) begin
      done_cnt++;
      last_data = o_rx_data;
    end
    if (o_rx_err) err_cnt++;
    if (o_rx_done && o_rx_err) overlap_cnt++;
    if (rst_n && !o_rx_done && (o_rx_data !== prev_data)) bad_change++;
    prev_data = o_rx_data;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bit_time(input logic v);
    rx = v;
    wait_cyc(C);
  endtask

  task automatic send_frame_bits(input logic [7:0] b);
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_cyc(C / 2);
      if (i == 4) busy_and = busy_and & o_rx_busy;
      wait_cyc(C / 2);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int nstop);
    send_frame_bits(b);
    for (int i = 0; i < nstop; i++) bit_time(1'b1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rx = 1'b1; len = 5'd0;
    wait_cyc(3);
    n_checks++;
    if (o_rx_data !== 128'h0) begin n_fail++; $display("FAIL reset_data: got %h required 0", o_rx_data); end
    n_checks++;
    if (o_rx_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b required 0", o_rx_done); end
    n_checks++;
    if (o_rx_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b required 0", o_rx_busy); end
    n_checks++;
    if (o_rx_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b required 0", o_rx_err); end
    n_checks++;
    if (o_err_code !== 2'b00) begin n_fail++; $display("FAIL reset_code: got %b required 00", o_err_code); end
    rst_n = 1'b1;
    wait_cyc(4);
  endtask

  task automatic test_deadbeef();
    int d0, e0;
    d0 = done_cnt; e0 = err_cnt; busy_and = 1'b1;
    len = 5'd4;
    send_byte(8'hDE, 2);
    send_byte(8'hAD, 2);
    send_byte(8'hBE, 2);
    send_byte(8'hEF, 2);
    n_checks++;
    if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL beef_done_count: got %0d required 1", done_cnt - d0); end
    n_checks++;
    if (o_rx_data !== 128'hDEADBEEF) begin n_fail++; $display("FAIL beef_data: got %h required %h", o_rx_data, 128'hDEADBEEF); end
    n_checks++;
    if (busy_and !== 1'b1) begin n_fail++; $display("FAIL beef_busy_during: got %b required 1", busy_and); end
    n_checks++;
    if (o_rx_busy !== 1'b0) begin n_fail++; $display("FAIL beef_busy_after: got %b required 0", o_rx_busy); end
    n_checks++;
    if (err_cnt != e0) begin n_fail++; $display("FAIL beef_err_count: got %0d required 0", err_cnt - e0); end
  endtask

  task automatic test_back_to_back();
    int d0;
    logic seen;
    logic [127:0] first_data;
    d0 = done_cnt;
    len = 5'd16;
    for (int i = 0; i < 15; i++) send_byte(8'(15 - i), 1);
    send_frame_bits(8'h00);
    rx = 1'b1;
    seen = 1'b0;
    first_data = '0;
    for (int k = 0; k < 3 * C && !seen; k++) begin
      @(negedge clk);
      if (o_rx_done) begin seen = 1'b1; first_data = o_rx_data; end
    end
    n_checks++;
    if (seen !== 1'b1) begin n_fail++; $display("FAIL b2b_first_done: got %b required 1", seen); end
    n_checks++;
    if (first_data !== 128'h0F0E0D0C0B0A09080706050403020100) begin
      n_fail++; $display("FAIL b2b_first_data: got %h required %h", first_data, 128'h0F0E0D0C0B0A09080706050403020100);
    end
    @(posedge clk); #1;
    for (int i = 0; i < 15; i++) send_byte(8'h10 + 8'(i), 1);
    send_byte(8'h1F, 2);
    n_checks++;
    if (o_rx_data !== 128'h101112131415161718191A1B1C1D1E1F) begin
      n_fail++; $display("FAIL b2b_second_data: got %h required %h", o_rx_data, 128'h101112131415161718191A1B1C1D1E1F);
    end
    n_checks++;
    if (done_cnt - d0 != 2) begin n_fail++; $display("FAIL b2b_done_count: got %0d required 2", done_cnt - d0); end
  endtask

  task automatic test_framing();
    int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    len = 5'd2;
    send_byte(8'h11, 2);
    send_frame_bits(8'h22);
    for (int i = 0; i < 6; i++) bit_time(1'b0);
    n_checks++;
    if (err_cnt - e0 != 1) begin n_fail++; $display("FAIL frm_err_count: got %0d required 1", err_cnt - e0); end
    n_checks++;
    if (o_err_code !== 2'b01) begin n_fail++; $display("FAIL frm_code: got %b required 01", o_err_code); end
    n_checks++;
    if (o_rx_data !== 128'h101112131415161718191A1B1C1D1E1F) begin
      n_fail++; $display("FAIL frm_data_kept: got %h required %h", o_rx_data, 128'h101112131415161718191A1B1C1D1E1F);
    end
    n_checks++;
    if (o_rx_busy !== 1'b0) begin n_fail++; $display("FAIL frm_busy: got %b required 0", o_rx_busy); end
    rx = 1'b1;
    wait_cyc(2 * C);
    len = 5'd1;
    send_byte(8'h3C, 2);
    n_checks++;
    if (o_rx_data !== 128'h3C) begin n_fail++; $display("FAIL frm_recover_data: got %h required %h", o_rx_data, 128'h3C); end
    n_checks++;
    if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL frm_done_count: got %0d required 1", done_cnt - d0); end
    n_checks++;
    if (err_cnt - e0 != 1) begin n_fail++; $display("FAIL frm_err_total: got %0d required 1", err_cnt - e0); end
  endtask

  task automatic test_timeout();
    int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    len = 5'd3;
    send_byte(8'hA1, 1);
    send_byte(8'hB2, 1);
    rx = 1'b1;
    wait_cyc(18 * C);
    n_checks++;
    if (err_cnt != e0) begin n_fail++; $display("FAIL to_early: got %0d errors required 0", err_cnt - e0); end
    n_checks++;
    if (o_rx_busy !== 1'b1) begin n_fail++; $display("FAIL to_busy_in_gap: got %b required 1", o_rx_busy); end
    wait_cyc(7 * C);
    n_checks++;
    if (err_cnt - e0 != 1) begin n_fail++; $display("FAIL to_err_count: got %0d required 1", err_cnt - e0); end
    n_checks++;
    if (o_err_code !== 2'b10) begin n_fail++; $display("FAIL to_code: got %b required 10", o_err_code); end
    n_checks++;
    if (done_cnt != d0) begin n_fail++; $display("FAIL to_no_done: got %0d required 0", done_cnt - d0); end
    n_checks++;
    if (o_rx_data !== 128'h3C) begin n_fail++; $display("FAIL to_data_kept: got %h required %h", o_rx_data, 128'h3C); end
    n_checks++;
    if (o_rx_busy !== 1'b0) begin n_fail++; $display("FAIL to_busy: got %b required 0", o_rx_busy); end
  endtask

  task automatic test_glitch_len0();
    int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    rx = 1'b0;
    wait_cyc(4);
    rx = 1'b1;
    wait_cyc(2 * C);
    n_checks++;
    if (err_cnt != e0 || done_cnt != d0) begin
      n_fail++; $display("FAIL glitch_flags: got err=%0d done=%0d required 0 0", err_cnt - e0, done_cnt - d0);
    end
    n_checks++;
    if (o_rx_busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy: got %b required 0", o_rx_busy); end
    n_checks++;
    if (o_err_code !== 2'b10) begin n_fail++; $display("FAIL glitch_code_held: got %b required 10", o_err_code); end
    len = 5'd0;
    send_byte(8'h5A, 2);
    n_checks++;
    if (o_rx_data !== 128'h5A) begin n_fail++; $display("FAIL len0_data: got %h required %h", o_rx_data, 128'h5A); end
    n_checks++;
    if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL len0_done_count: got %0d required 1", done_cnt - d0); end
  endtask

  task automatic test_reset_mid();
    int d0, e0;
    len = 5'd4;
    send_byte(8'h01, 1);
    send_byte(8'h02, 1);
    bit_time(1'b0);
    rx = 1'b1;
    wait_cyc(C / 2);
    rst_n = 1'b0;
    #2;
    n_checks++;
    if (o_rx_data !== 128'h0) begin n_fail++; $display("FAIL rstmid_data: got %h required 0", o_rx_data); end
    n_checks++;
    if (o_rx_busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b required 0", o_rx_busy); end
    n_checks++;
    if (o_err_code !== 2'b00 || o_rx_err !== 1'b0 || o_rx_done !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_flags: got code=%b err=%b done=%b required 00 0 0", o_err_code, o_rx_err, o_rx_done);
    end
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(2 * C);
    d0 = done_cnt; e0 = err_cnt;
    len = 5'd4;
    send_byte(8'hCA, 2);
    send_byte(8'hFE, 2);
    send_byte(8'hBA, 2);
    send_byte(8'hBE, 2);
    n_checks++;
    if (o_rx_data !== 128'hCAFEBABE) begin n_fail++; $display("FAIL rstmid_new_data: got %h required %h", o_rx_data, 128'hCAFEBABE); end
    n_checks++;
    if (done_cnt - d0 != 1 || err_cnt != e0) begin
      n_fail++; $display("FAIL rstmid_counts: got done=%0d err=%0d required 1 0", done_cnt - d0, err_cnt - e0);
    end
  endtask

  initial begin
    test_reset();
    test_deadbeef();
    test_back_to_back();
    test_framing();
    test_timeout();
    test_glitch_len0();
    test_reset_mid();
    wait_cyc(4);
    n_checks++;
    if (overlap_cnt != 0) begin n_fail++; $display("FAIL done_err_overlap: got %0d required 0", overlap_cnt); end
    n_checks++;
    if (bad_change != 0) begin n_fail++; $display("FAIL data_stability: got %0d changes outside done required 0", bad_change); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_rx_frame.md
# uart_rx_frame

Multi-byte UART receiver, the receive-side counterpart of the team's 128-bit message transmitter. It samples the serial line at mid-bit, assembles up to 16 bytes into one 128-bit word, and pulses `rx_done` when the configured number of bytes has arrived. Bytes follow the transmitter's ordering: most-significant byte first on the wire, bits LSB first within each byte. It sits between the board RX pin and the CPU-side debug/data register file.

## Interface
- `CLKS_PER_BIT`, 5208, clock cycles per bit (50 MHz / 9600 baud); must equal the transmitter's bit period.
- `TIMEOUT_BITS`, 20, idle bit-times allowed between bytes of one message before the message is aborted.
- `clk  input  1  system clock; all logic on posedge`
- `rst_n  input  1  reset, asynchronous, active-low`
- `rx_pin_in  input  1  serial line; idle high; asynchronous to clk`
- `len  input  5  bytes per message; sampled at each message's first start bit`
- `rx_data  output  128  last completed message; unused upper bytes zero`
- `rx_done  output  1  one-cycle pulse; rx_data valid from this cycle on`
- `rx_busy  output  1  high from a message's first valid start bit until done/abort`
- `rx_err  output  1  one-cycle pulse on abort`
- `err_code  output  2  01 framing, 10 timeout; valid with rx_err, held until next error`

## Operation
- `rx_pin_in` passes through a 2-flop synchronizer (reset value 1). All references below are to the synchronized signal `rxs`.
- Length capture: `len` is latched into `msg_len` at the first start bit of a message. Values 0 and 1 both mean 1; values above 16 clamp to 16. `byte_idx` counts from 0 to msg_len-1.
- Byte placement: byte k is written to `shreg[8*(msg_len-1-k) +: 8]`. `shreg` is cleared at message start. At done, `rx_data <= shreg`.
- States:
  - IDLE: `rxs==0` → START, with the bit counter loaded to sample at CLKS_PER_BIT/2.
  - START: at the half-bit sample, `rxs==1` is a false start → IDLE, with no flags and `byte_idx` unchanged. Otherwise → DATA. The first valid start sets `rx_busy`.
  - DATA: samples 8 bits, one every CLKS_PER_BIT, LSB first, into the byte shifter. After bit 7 → STOP.
  - STOP: samples one bit-time later.
    - `rxs==1` and not the last byte: store the byte, `byte_idx++` → GAP.
    - `rxs==1` and last byte: store, update `rx_data`, pulse `rx_done`, clear `rx_busy` → IDLE.
    - `rxs==0`: pulse `rx_err` with err_code=01, clear `rx_busy`, discard the message → WAIT_HIGH.
  - GAP: waiting for the next byte; the timeout counter is running.
    - `rxs==0` → START (no `len` re-capture).
    - TIMEOUT_BITS*CLKS_PER_BIT cycles elapse → `rx_err` with err_code=10, clear `rx_busy` → IDLE.
  - WAIT_HIGH: stays until `rxs==1` → IDLE.
- Only the first stop bit is checked; the transmitter's second stop bit appears as idle time.
- A false start in GAP returns to GAP, not IDLE; the timeout counter keeps running.
- Reset mid-message: state=IDLE, shreg=0, `rx_data` cleared to 0, and all flags 0. The partial message is lost.

## Timing
- Reset values:
  - `rx_data=0`, `rx_done=0`, `rx_busy=0`, `rx_err=0`, `err_code=00`.
  - Synchronizer flops =1, state=IDLE.
- Start-edge detection: 2 cycles after the `rx_pin_in` fall (synchronizer delay).
- Sample points: start bit at edge+CLKS_PER_BIT/2; data bit n at edge+CLKS_PER_BIT/2+(n+1)*CLKS_PER_BIT; stop bit at +9*CLKS_PER_BIT.
- `rx_done`/`rx_err` assert the cycle after the stop sample, last exactly 1 cycle, and never coincide.
- `rx_data` changes only in the `rx_done` cycle and is otherwise stable.
- Back-to-back messages: a start edge in the cycle after `rx_done` is accepted.
- Tolerance: the receiver must accept ±3% baud mismatch.

## Structure
- Package `uart_pkg`:
  - state enum (IDLE, START, DATA, STOP, GAP, WAIT_HIGH)
  - `ERR_FRAMING=2'b01`, `ERR_TIMEOUT=2'b10`
  - default `CLKS_PER_BIT`
  - `MAX_BYTES=16`
- Sub-module `rx_bps_module`: bit-period counter.
  - Inputs: enable, half-load.
  - Output: single-cycle `sample_tick`.
  - Reused by the GAP timeout via a bit-time count.
- Top level holds the synchronizer, FSM, shifter, and output registers.

## Test plan
(CLKS_PER_BIT=16, TIMEOUT_BITS=20 in simulation.)
- len=4; send 0xDE,0xAD,0xBE,0xEF with 2 stop bits each → one `rx_done`; rx_data=0x...0000_DEADBEEF (upper 96 bits zero); `rx_busy` high throughout.
- len=16; send bytes 0x0F..0x00 back-to-back; then a second len=16 message starting the cycle after `rx_done` → both received; first rx_data=128'h0F0E..0100.
- len=2; second byte's stop bit driven low → `rx_err`, err_code=01, rx_data unchanged; line held low 5 bits then released → back to IDLE; the next valid 1-byte message is received.
- len=3; send 2 bytes then idle 25 bit-times → `rx_err` at the 20th bit-time, err_code=10, no `rx_done`.
- Glitch: line low for 4 cycles (< half bit) in IDLE → no state change beyond START→IDLE, no flags. len=0 with one byte 0x5A → rx_data=0x5A, `rx_done` once.
- Assert `rst_n` low mid-byte of a len=4 message → all outputs 0 asynchronously; after release, a full new message is received correctly.
